// File: rtl/eflags_cond_unit.sv
// EFLAGS register, pending flag-writer scoreboard and x86 condition evaluator.
// This block sits beside the ALU in the execute stage.
// - eflags_as_src comes straight from a flop, so there is no combinational loop back into the ALU.
// - Condition requests are evaluated against the next EFLAGS value, so a same-cycle ALU or
//   software write is bypassed into the result.

`ifndef EFLAGS_CF
`define EFLAGS_CF 0
`endif
`ifndef EFLAGS_PF
`define EFLAGS_PF 2
`endif
`ifndef EFLAGS_ZF
`define EFLAGS_ZF 6
`endif
`ifndef EFLAGS_SF
`define EFLAGS_SF 7
`endif
`ifndef EFLAGS_OF
`define EFLAGS_OF 11
`endif

module eflags_cond_unit #(
  parameter int unsigned PEND_W = 3,
  parameter int unsigned REG_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [REG_W-1:0]  alu_eflags,
  input  logic              alu_eflags_update,
  output logic [REG_W-1:0]  eflags_as_src,
  input  logic              wr_issue,
  output logic              issue_ready,
  input  logic              sw_we,
  input  logic [REG_W-1:0]  sw_data,
  input  logic              flush,
  input  logic              cc_valid,
  input  logic [3:0]        cc,
  output logic              cc_ready,
  output logic              cc_done,
  output logic              cc_taken,
  output logic [PEND_W-1:0] pending
);

  localparam int unsigned BitCf = `EFLAGS_CF;
  localparam int unsigned BitPf = `EFLAGS_PF;
  localparam int unsigned BitZf = `EFLAGS_ZF;
  localparam int unsigned BitSf = `EFLAGS_SF;
  localparam int unsigned BitOf = `EFLAGS_OF;

  // Bit 1 of EFLAGS is architecturally reserved and always reads as one.
  localparam logic [REG_W-1:0] FixedOnes = REG_W'(2);
  localparam logic [REG_W-1:0] ResetVal  = REG_W'(2);
  localparam logic [PEND_W-1:0] PendMax  = {PEND_W{1'b1}};

  logic [REG_W-1:0]  eflags_q, eflags_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              cc_done_q, cc_done_d;
  logic              cc_taken_q, cc_taken_d;

  logic pend_zero;
  logic pend_one;
  logic pend_full;
  logic issue_acc;
  logic retire;
  logic cc_accept;
  logic cc_result;

  // Evaluates condition code cc (tttn encoding) against flags.
  // Bits [3:1] pick the base predicate and bit 0 inverts it.
  function automatic logic eval_cc(input logic [3:0] code, input logic [REG_W-1:0] flags);
    logic cf, pf, zf, sf, of_f;
    logic base;
    cf   = flags[BitCf];
    pf   = flags[BitPf];
    zf   = flags[BitZf];
    sf   = flags[BitSf];
    of_f = flags[BitOf];
    unique case (code[3:1])
      3'd0:    base = of_f;
      3'd1:    base = cf;
      3'd2:    base = zf;
      3'd3:    base = cf | zf;
      3'd4:    base = sf;
      3'd5:    base = pf;
      3'd6:    base = sf ^ of_f;
      3'd7:    base = zf | (sf ^ of_f);
      default: base = 1'b0;
    endcase
    return base ^ code[0];
  endfunction

  // Scoreboard status and handshake outputs.
  always_comb begin
    pend_zero   = (pending_q == '0);
    pend_one    = (pending_q == PEND_W'(1));
    pend_full   = (pending_q == PendMax);
    // A retire in the same cycle frees a slot, so a full counter can still accept an issue.
    issue_ready = ~pend_full | alu_eflags_update;
    issue_acc   = wr_issue & issue_ready;
    // An unannounced ALU write at zero still updates the flags but does not underflow the counter.
    retire      = alu_eflags_update & ~pend_zero;
    // The last outstanding writer retiring this cycle is fine, unless a new writer also issues now.
    cc_ready    = pend_zero | (pend_one & alu_eflags_update & ~wr_issue);
    cc_accept   = cc_valid & cc_ready & ~flush;
  end

  // EFLAGS next value: a software write has priority over the ALU result.
  always_comb begin
    eflags_d = eflags_q;
    if (sw_we) begin
      eflags_d = sw_data | FixedOnes;
    end else if (alu_eflags_update) begin
      eflags_d = alu_eflags | FixedOnes;
    end
  end

  // Pending counter next value: flush clears it, and issue plus retire together cancel out.
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else if (issue_acc && !retire) begin
      pending_d = pending_q + 1'b1;
    end else if (!issue_acc && retire) begin
      pending_d = pending_q - 1'b1;
    end
  end

  // Condition result is taken from the bypassed next-state flags.
  always_comb begin
    cc_result  = eval_cc(cc, eflags_d);
    cc_done_d  = cc_accept;
    cc_taken_d = cc_taken_q;
    if (cc_accept) begin
      cc_taken_d = cc_result;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      eflags_q   <= ResetVal;
      pending_q  <= '0;
      cc_done_q  <= 1'b0;
      cc_taken_q <= 1'b0;
    end else begin
      eflags_q   <= eflags_d;
      pending_q  <= pending_d;
      cc_done_q  <= cc_done_d;
      cc_taken_q <= cc_taken_d;
    end
  end

  // Output ports are driven directly from the registers.
  always_comb begin
    eflags_as_src = eflags_q;
    pending       = pending_q;
    cc_done       = cc_done_q;
    cc_taken      = cc_taken_q;
  end

endmodule

// File: doc/eflags_cond_unit.md
Name: eflags_cond_unit

Overview:
- Consumer end of the ALU flag interface. Holds the architectural EFLAGS register and drives it back to the ALU as eflags_as_src.
- Absorbs ALU flag updates and software flag writes (popf-style).
- Evaluates x86 condition codes for Jcc/SETcc/CMOVcc, with a pending-writer scoreboard.
- Sits beside the ALU in the execute stage. Decode announces flag writers; branch/setcc logic requests conditions.

Parameters:
PEND_W, 3, width of the pending flag-writer counter (max outstanding writers = 2**PEND_W-1)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
alu_eflags  in  REG_W  flag result from ALU (eflags output)
alu_eflags_update  in  1  ALU flag write strobe; also retires one pending writer
eflags_as_src  out  REG_W  registered architectural EFLAGS, fed to ALU
wr_issue  in  1  decode announces one flag writer in flight
issue_ready  out  1  pending counter not full
sw_we  in  1  software full-EFLAGS write
sw_data  in  REG_W  software write data
flush  in  1  pipeline flush; clears scoreboard
cc_valid  in  1  condition evaluation request
cc  in  4  x86 condition code (tttn)
cc_ready  out  1  request can be accepted this cycle
cc_done  out  1  result valid (one cycle after acceptance)
cc_taken  out  1  condition result, valid when cc_done
pending  out  PEND_W  current pending-writer count (debug/perf)

Behaviour:
- Reset (rstn=0 at posedge): EFLAGS=REG_W'(2) (bit1 set, others 0); pending=0; cc_done=0; cc_taken=0. issue_ready=1 and cc_ready=1 follow combinationally.
- eflags_as_src is the register output only. No combinational path from alu_eflags, which avoids an ALU loop.
- EFLAGS next value:
  - sw_we: sw_data with bit1 forced 1.
  - else alu_eflags_update: alu_eflags with bit1 forced 1.
  - else hold.
  - sw_we and alu_eflags_update in the same cycle: sw_we wins for data; the ALU strobe still retires a writer.
- Pending counter, per cycle:
  - flush=1: pending<=0. wr_issue and retire in that cycle are ignored.
  - else pending <= pending + (wr_issue & issue_ready) - (alu_eflags_update & pending!=0).
  - Issue and retire in the same cycle: net unchanged.
  - Retire at pending=0 (unannounced ALU write): flags still written, counter stays 0 (no underflow).
- issue_ready = (pending != 2**PEND_W-1) | alu_eflags_update. A same-cycle retire frees a slot. wr_issue while !issue_ready is dropped and must be held by decode.
- cc_ready = (pending==0) | (pending==1 & alu_eflags_update & !wr_issue).
- Acceptance = cc_valid & cc_ready & !flush.
- On acceptance, the condition is evaluated against the EFLAGS next value (bypass of the same-cycle ALU/sw write). The result is registered: cc_done=1 and cc_taken=result in the following cycle. Otherwise cc_done<=0 and cc_taken holds.
- Condition evaluation uses the `EFLAGS_CF/PF/ZF/SF/OF positions:
  - 0 O: OF. 1 NO: !OF.
  - 2 B: CF. 3 AE: !CF.
  - 4 E: ZF. 5 NE: !ZF.
  - 6 BE: CF|ZF. 7 A: !(CF|ZF).
  - 8 S: SF. 9 NS: !SF.
  - A P: PF. B NP: !PF.
  - C L: SF^OF. D GE: !(SF^OF).
  - E LE: ZF|(SF^OF). F G: !(ZF|(SF^OF)).
- flush does not alter EFLAGS contents. An accepted request in the flush cycle is impossible, because acceptance is gated by !flush.
- Reset mid-operation overrides everything. A cc_done due in that cycle is suppressed (0).

Test Plan:
- Reset: hold rstn=0 two cycles -> eflags_as_src=0x2, pending=0, cc_ready=1, issue_ready=1, cc_done=0.
- ALU write + bypassed cc: with pending=0, alu_eflags_update=1, alu_eflags=0x40 (ZF), cc_valid=1, cc=4 -> next cycle eflags_as_src=0x42, cc_done=1, cc_taken=1. Repeat with cc=5 -> cc_taken=0.
- Scoreboard stall: wr_issue twice (pending=2), cc_valid=1 cc=2 -> cc_ready=0. First retire -> pending=1. Second retire with alu_eflags=0x1 -> accepted that cycle, next cycle cc_taken=1.
- Full counter (PEND_W=3): issue 7 -> pending=7, issue_ready=0. 8th wr_issue alone is dropped (pending stays 7). 8th wr_issue with a same-cycle retire -> pending stays 7, issue accepted.
- Signed conditions: sw_we=1 sw_data=0x880 (SF,OF) -> eflags_as_src=0x882. cc=C -> 0, cc=D -> 1, cc=F -> 1. Then sw_data=0x80 -> cc=C -> 1, cc=E -> 1.
- Flush / conflicts:
  - pending=3, flush=1 with wr_issue=1 -> pending=0, EFLAGS unchanged.
  - sw_we and alu_eflags_update together (0x1 vs 0x40) -> EFLAGS=0x3.
  - alu_eflags_update at pending=0 -> pending stays 0.
